// File: rtl/prog_divider.sv
// prog_divider: run-time programmable clock divider with square or pulse output.
// Define DIV_SYNC_EN to pass enable_i through a 2-flop synchroniser.
module prog_divider #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEF_RATIO = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] ratio_i,
    input  logic             ratio_load_i,
    input  logic             mode_i,
    output logic             sig_no,
    output logic             tick_o,
    output logic             pend_o
);

    logic en;

`ifdef DIV_SYNC_EN
    logic en_s1_q;
    logic en_s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_s1_q <= 1'b0;
            en_s2_q <= 1'b0;
        end else begin
            en_s1_q <= enable_i;
            en_s2_q <= en_s1_q;
        end
    end

    assign en = en_s2_q;
`else
    assign en = enable_i;
`endif

    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] pratio_q, pratio_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] h_act;
    logic             wrap;

    // Ratios 0 and 1 clamp to 2; the low phase takes the extra cycle for odd N.
    assign n_eff = (ratio_q >= CNT_W'(2)) ? ratio_q : CNT_W'(2);
    assign h_act = n_eff - (n_eff >> 1);
    assign wrap  = (cnt_q == (n_eff - CNT_W'(1)));

    always_comb begin
        ratio_d  = ratio_q;
        pratio_d = pratio_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        sig_d    = 1'b1;

        if (en) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (pend_q) begin
                    ratio_d = pratio_q;
                    pend_d  = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (mode_i) begin
                sig_d = (cnt_d != '0);
            end else begin
                sig_d = (cnt_d >= h_act);
            end
        end else if (pend_q) begin
            ratio_d = pratio_q;
            pend_d  = 1'b0;
            cnt_d   = '0;
        end

        // A load on the apply edge is captured after the old pending value is consumed.
        if (ratio_load_i) begin
            pratio_d = ratio_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ratio_q  <= CNT_W'(DEF_RATIO);
            pratio_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            sig_q    <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            ratio_q  <= ratio_d;
            pratio_q <= pratio_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
            tick_q   <= tick_d;
        end
    end

    assign sig_no = sig_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: tb/tb_prog_divider.sv
// Scoreboard bench for prog_divider: directed vectors push expected outputs, a monitor pops and compares.
module tb_prog_divider;

    localparam int unsigned CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             enable_i = 1'b0;
    logic [CNT_W-1:0] ratio_i = '0;
    logic             ratio_load_i = 1'b0;
    logic             mode_i = 1'b0;
    logic             sig_no;
    logic             tick_o;
    logic             pend_o;

    prog_divider #(.CNT_W(CNT_W), .DEF_RATIO(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .ratio_i      (ratio_i),
        .ratio_load_i (ratio_load_i),
        .mode_i       (mode_i),
        .sig_no       (sig_no),
        .tick_o       (tick_o),
        .pend_o       (pend_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] seg;
        logic        s;
        logic        t;
        logic        p;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   seg_id = 0;

    // Monitor: each clock edge (or async reset assertion) consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i or negedge rst_ni);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({sig_no, tick_o, pend_o} !== {e.s, e.t, e.p}) begin
                    n_miss++;
                    $display("FAIL seg%0d vec%0d: sig/tick/pend got %b%b%b expected %b%b%b",
                             e.seg, n_vec, sig_no, tick_o, pend_o, e.s, e.t, e.p);
                end
            end
        end
    end

    task automatic push(input logic s, input logic t, input logic p);
        exp_t e;
        e.seg = 16'(seg_id);
        e.s   = s;
        e.t   = t;
        e.p   = p;
        exp_q.push_back(e);
    endtask

    // One cycle: drive at negedge, expect outputs after the following posedge.
    task automatic cyc(input logic en, input logic ld, input int r, input logic md,
                       input logic es, input logic et, input logic ep);
        enable_i     = en;
        ratio_load_i = ld;
        ratio_i      = CNT_W'(r);
        mode_i       = md;
        push(es, et, ep);
        @(negedge clk_i);
        ratio_load_i = 1'b0;
    endtask

    task automatic seq(input logic en, input logic md,
                       input string s, input string t, input string p);
        seg_id++;
        for (int i = 0; i < s.len(); i++) begin
            cyc(en, 1'b0, 0, md, s[i] == "1", t[i] == "1", p[i] == "1");
        end
    endtask

    task automatic reset_mid();
        seg_id++;
        enable_i     = 1'b0;
        ratio_load_i = 1'b0;
        push(1'b1, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        push(1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        @(negedge clk_i);
        rst_ni = 1'b1;

        seq(0, 0, "111", "000", "000");
        seq(1, 0, "00110001100011000110", "00001000010000100001", "00000000000000000000");
        seq(1, 1, "1111011110", "0000100001", "0000000000");

        // Reload 8 at cnt=2: current period completes at 5, then 4 low / 4 high.
        seq(1, 0, "00", "00", "00");
        seg_id++;
        cyc(1, 1, 8, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        seq(1, 0, "0001111000011110", "0000000100000001", "0000000000000000");

        // Ratio 0 and 1 clamp to period 2.
        seg_id++;
        cyc(1, 1, 0, 0, 0, 0, 1);
        seq(1, 0, "0011110", "0000001", "1111110");
        seq(1, 0, "1010", "0101", "0000");
        seg_id++;
        cyc(1, 1, 1, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        seq(1, 0, "1010", "0101", "0000");

        // Load while disabled with cnt=1: applied next edge, phase restarts.
        seg_id++;
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 3, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0);
        seq(1, 0, "010010", "001001", "000000");

        // Double load 6 then 9: only 9 takes effect (5 low, 4 high).
        seg_id++;
        cyc(1, 1, 6, 0, 0, 0, 1);
        cyc(1, 1, 9, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        seq(1, 0, "000011110", "000000001", "000000000");

        // Load coinciding with apply: 4 applied, 2 stays pending.
        seg_id++;
        cyc(1, 1, 4, 0, 0, 0, 1);
        seq(1, 0, "0001111", "0000000", "1111111");
        seg_id++;
        cyc(1, 1, 2, 0, 0, 1, 1);
        seq(1, 0, "0110", "0001", "1110");
        seq(1, 0, "1010", "0101", "0000");

        // Reach cnt=3 with a pending ratio, then reset asynchronously.
        seg_id++;
        cyc(1, 1, 7, 0, 1, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 0);
        seq(1, 0, "00", "00", "00");
        seg_id++;
        cyc(1, 1, 12, 0, 0, 0, 1);
        reset_mid();
        seq(1, 0, "0011000110", "0000100001", "0000000000");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
